// File: rtl/date_pkg.sv
// Calendar constants and helpers shared by the date register, the day-of-week stage and bench models.
package date_pkg;

    localparam int unsigned MONTH_MAX = 12;
    localparam int unsigned Y400      = 400;
    localparam int unsigned DAY_W     = 7;
    localparam int unsigned MON_W     = 7;
    localparam int unsigned YEAR_W    = 15;
    localparam int unsigned RES_W     = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REDUCE,
        ST_CHECK
    } load_state_e;

    // Out-of-range months return 31; callers validate the month separately.
    function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] month,
                                                       input logic leap);
        logic [DAY_W-1:0] dim;
        case (month)
            7'd4, 7'd6, 7'd9, 7'd11: dim = 7'd30;
            7'd2:                    dim = 7'd28 + {6'd0, leap};
            default:                 dim = 7'd31;
        endcase
        return dim;
    endfunction

    function automatic logic is_leap(input logic [1:0] year_lo2,
                                     input logic [RES_W-1:0] res400);
        return (year_lo2 == 2'd0) && (res400 != 9'd100) &&
               (res400 != 9'd200) && (res400 != 9'd300);
    endfunction

endpackage

// File: rtl/date_mod400_reducer.sv
// Iterative year-mod-400 reduction: one subtraction of 400 per cycle until the residue drops below 400.
module date_mod400_reducer
    import date_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [YEAR_W-1:0] year_i,
    output logic              done_o,
    output logic [RES_W-1:0]  r_o
);

    logic              active_q, active_d;
    logic [YEAR_W-1:0] r_q, r_d;
    logic              ge400;

    assign ge400 = {1'b0, r_q} >= 16'(Y400);
    assign r_o   = r_q[RES_W-1:0];

    always_comb begin
        active_d = active_q;
        r_d      = r_q;
        done_o   = 1'b0;
        if (start_i) begin
            r_d      = year_i;
            active_d = 1'b1;
        end else if (active_q) begin
            if (ge400) begin
                r_d = r_q - YEAR_W'(Y400);
            end else begin
                active_d = 1'b0;
                done_o   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            r_q      <= '0;
        end else begin
            active_q <= active_d;
            r_q      <= r_d;
        end
    end

endmodule

// File: rtl/date_counter.sv
// Calendar date register: advances one day per DayTick and accepts validated loads via a req/busy/done handshake.
module date_counter
    import date_pkg::*;
#(
    parameter int unsigned YEAR_MAX   = 32767,
    parameter int unsigned RESET_YEAR = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              DayTick,
    input  logic              SetReq,
    input  logic [DAY_W-1:0]  SetDays,
    input  logic [MON_W-1:0]  SetMonths,
    input  logic [YEAR_W-1:0] SetYears,
    output logic [DAY_W-1:0]  days,
    output logic [MON_W-1:0]  months,
    output logic [YEAR_W-1:0] years,
    output logic              ClkLeap,
    output logic              Busy,
    output logic              SetDone,
    output logic              SetErr,
    output logic              YearWrap
);

    localparam logic [YEAR_W-1:0] YMAX       = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] RST_YEAR   = YEAR_W'(RESET_YEAR);
    localparam int unsigned       RST_RES    = RESET_YEAR % Y400;
    localparam logic [RES_W-1:0]  RST_Y400   = RES_W'(RST_RES);
    localparam logic              RST_LEAP   = ((RESET_YEAR % 4) == 0) && (RST_RES != 100) &&
                                               (RST_RES != 200) && (RST_RES != 300);

    load_state_e       state_q, state_d;
    logic [DAY_W-1:0]  days_q, days_d;
    logic [MON_W-1:0]  mon_q, mon_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic [RES_W-1:0]  y400_q, y400_d;
    logic              leap_q, leap_d;
    logic [DAY_W-1:0]  sd_q, sd_d;
    logic [MON_W-1:0]  sm_q, sm_d;
    logic [YEAR_W-1:0] sy_q, sy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wrap_q, wrap_d;

    logic              red_start;
    logic              red_done;
    logic [RES_W-1:0]  red_r;
    logic              chk_leap;
    logic              chk_valid;
    logic [RES_W-1:0]  y400_inc;

    date_mod400_reducer u_reducer (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .start_i (red_start),
        .year_i  (SetYears),
        .done_o  (red_done),
        .r_o     (red_r)
    );

    assign chk_leap  = is_leap(sy_q[1:0], red_r);
    assign chk_valid = (sm_q >= 7'd1) && (sm_q <= MON_W'(MONTH_MAX)) &&
                       (sd_q >= 7'd1) && (sd_q <= days_in_month(sm_q, chk_leap)) &&
                       (sy_q >= 15'd1) && (sy_q <= YMAX);
    assign y400_inc  = (y400_q == 9'd399) ? '0 : y400_q + 9'd1;

    always_comb begin
        state_d   = state_q;
        days_d    = days_q;
        mon_d     = mon_q;
        year_d    = year_q;
        y400_d    = y400_q;
        leap_d    = leap_q;
        sd_d      = sd_q;
        sm_d      = sm_q;
        sy_d      = sy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        wrap_d    = 1'b0;
        red_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (DayTick) begin
                    if (days_q < days_in_month(mon_q, leap_q)) begin
                        days_d = days_q + 7'd1;
                    end else if (mon_q < MON_W'(MONTH_MAX)) begin
                        days_d = 7'd1;
                        mon_d  = mon_q + 7'd1;
                    end else if (year_q == YMAX) begin
                        days_d = 7'd1;
                        mon_d  = 7'd1;
                        year_d = 15'd1;
                        y400_d = 9'd1;
                        leap_d = 1'b0;
                        wrap_d = 1'b1;
                    end else begin
                        days_d = 7'd1;
                        mon_d  = 7'd1;
                        year_d = year_q + 15'd1;
                        y400_d = y400_inc;
                        leap_d = is_leap(year_d[1:0], y400_inc);
                    end
                end
                // A simultaneous tick still lands; the load result overwrites it at CHECK.
                if (SetReq) begin
                    sd_d      = SetDays;
                    sm_d      = SetMonths;
                    sy_d      = SetYears;
                    red_start = 1'b1;
                    state_d   = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                if (red_done) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (chk_valid) begin
                    days_d = sd_q;
                    mon_d  = sm_q;
                    year_d = sy_q;
                    y400_d = red_r;
                    leap_d = chk_leap;
                    done_d = 1'b1;
                end else begin
                    err_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            days_q  <= 7'd1;
            mon_q   <= 7'd1;
            year_q  <= RST_YEAR;
            y400_q  <= RST_Y400;
            leap_q  <= RST_LEAP;
            sd_q    <= '0;
            sm_q    <= '0;
            sy_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            days_q  <= days_d;
            mon_q   <= mon_d;
            year_q  <= year_d;
            y400_q  <= y400_d;
            leap_q  <= leap_d;
            sd_q    <= sd_d;
            sm_q    <= sm_d;
            sy_q    <= sy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign days     = days_q;
    assign months   = mon_q;
    assign years    = year_q;
    assign ClkLeap  = leap_q;
    assign Busy     = (state_q != ST_IDLE);
    assign SetDone  = done_q;
    assign SetErr   = err_q;
    assign YearWrap = wrap_q;

endmodule

// File: doc/date_counter.md
Name: date_counter

Overview:
- Calendar date register that drives the day-of-week stage. It holds days/months/years and the leap flag ClkLeap, and advances one calendar day per DayTick pulse.
- Supports a multi-cycle validated date load through a req/busy/done handshake. The year-mod-400 residue is computed iteratively, so no divider is used.
- Outputs feed the day-of-week stage directly: days[6:0], months[6:0], years[14:0], and ClkLeap, which is high in leap years.

Parameters:
- YEAR_MAX, 32767, highest legal year; must fit 15 bits.
- RESET_YEAR, 1, year loaded on reset. Must be non-leap, or the reset values of ClkLeap and y400 change accordingly.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- DayTick  in  1  single-cycle pulse: advance the date by one day.
- SetReq  in  1  request to load SetDays/SetMonths/SetYears; sampled only when Busy=0.
- SetDays  in  7  day to load, legal 1..days-in-month.
- SetMonths  in  7  month to load, legal 1..12.
- SetYears  in  15  year to load, legal 1..YEAR_MAX.
- days  out  7  current day of month.
- months  out  7  current month.
- years  out  15  current year.
- ClkLeap  out  1  high when `years` is a leap year.
- Busy  out  1  load in progress.
- SetDone  out  1  one-cycle pulse: load committed.
- SetErr  out  1  one-cycle pulse: load rejected; date unchanged.
- YearWrap  out  1  one-cycle pulse: date rolled from YEAR_MAX-12-31 to 0001-01-01.

Behaviour:
- **Reset (asynchronous):**
  - days=1, months=1, years=RESET_YEAR, y400=RESET_YEAR mod 400, ClkLeap=0.
  - Busy, SetDone, SetErr and YearWrap all 0; FSM in IDLE.
  - Reset asserted mid-load aborts the load. No SetDone or SetErr is produced.
- **Leap rule:** ClkLeap = (years[1:0]==0) && (y400 ∉ {100,200,300}).
  - y400 is an internal 9-bit residue, years mod 400.
  - ClkLeap is registered and updates on the same edge as years.
- **DayTick in IDLE**, applied at the sampling edge:
  - If days < dim(months, ClkLeap): days+1.
  - Else if months < 12: days=1, months+1.
  - Else: days=1, months=1, years+1, y400 = (y400==399 ? 0 : y400+1), ClkLeap recomputed for the new year.
  - At YEAR_MAX-12-31: roll to 0001-01-01, y400=1, YearWrap=1 for one cycle.
- **dim:** 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; month 2 gives 28+ClkLeap (or 28+leap of the candidate year during CHECK).
- **Load FSM: IDLE → REDUCE → CHECK → IDLE.**
  - IDLE, SetReq=1: latch the Set* inputs into shadow registers, r=SetYears, go to REDUCE; Busy=1 from the next cycle.
  - REDUCE: if r ≥ 400, r = r−400 and stay; else go to CHECK. Takes floor(Y/400)+1 cycles.
  - CHECK (one cycle): valid iff 1≤M≤12, 1≤D≤dim(M, leap(Y[1:0], r)), and 1≤Y≤YEAR_MAX.
    - If valid, commit on the edge ending CHECK: days/months/years=D/M/Y, y400=r, ClkLeap updated.
    - Return to IDLE. Busy falls. SetDone (valid) or SetErr (invalid) is high for exactly the next cycle.
  - Total Busy duration = floor(Y/400)+2 cycles.
- **Simultaneous events:**
  - DayTick is ignored whenever Busy=1 or FSM ≠ IDLE (discarded, not queued).
  - If SetReq and DayTick arrive in the same IDLE cycle, the tick applies and the load starts. The load result overwrites the ticked date.
  - SetReq while Busy=1 is ignored. Shadow registers are unaffected by input changes after acceptance.
- **Widths:**
  - Arithmetic is unsigned.
  - The 15-bit year compare to 400 is done in ≥16-bit width.
  - SetDays/SetMonths values above the legal range (up to 127) give SetErr.
  - SetYears=0 gives SetErr.

Decomposition:
- **Shared package date_pkg:**
  - Constants: MONTH_MAX=12, Y400=400, and field widths DAY_W=7, MON_W=7, YEAR_W=15.
  - Function days_in_month(month, leap).
  - Function is_leap(year_lo2, res400).
  - These are reused by the day-of-week stage and by bench models.
- **Sub-module date_mod400_reducer:** the REDUCE datapath with start/done handshake, producing r. The top level keeps the calendar registers and the IDLE/CHECK control.

Test Plan:
- Reset → 0001-01-01, ClkLeap=0, Busy=0. The downstream day-of-week output equals 1.
- Load 2024-02-28 → Busy high for 7 cycles, then SetDone. Two DayTicks give 2024-02-29 then 2024-03-01, with ClkLeap=1 throughout.
- Load 1900-02-28 → ClkLeap=0, and one DayTick gives 1900-03-01. Load 2000-02-28 → ClkLeap=1, and one DayTick gives 2000-02-29.
- Load 2023-12-31, then DayTick → 2024-01-01 and ClkLeap rises on that edge. Load 32767-12-31, then DayTick → 0001-01-01 with a YearWrap pulse.
- Invalid loads each give SetErr with the date unchanged: 2023-02-29, 2024-13-01, 2024-04-31, 0000-01-01, and day 0.
- Load 2024-06-15, then pulse DayTick and a second SetReq while Busy=1 → both ignored, and the final date is 2024-06-15. Assert Reset mid-REDUCE → date becomes 0001-01-01 with no SetDone or SetErr pulse.
